// File: rtl/zap_regf_mp_pkg.sv
`timescale 1ns/1ps
// Shared types for the zap_regf_mp multi-port register file.
// The clear engine state encoding is fixed so debug tooling can decode it directly.
package zap_regf_mp_pkg;

  typedef enum logic {
    StClear = 1'b0,
    StIdle  = 1'b1
  } regf_state_e;

endpackage

// File: rtl/zap_regf_mp_if.sv
`timescale 1ns/1ps
// Access bus of zap_regf_mp: packed write/read port groups plus clear request and busy.
// Port p of a packed group occupies bits [p*W +: W].
interface zap_regf_mp_if #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned RD_PORTS = 4,
  parameter int unsigned WR_PORTS = 2
);

  logic                         i_clr;
  logic [WR_PORTS-1:0]          i_wen;
  logic [WR_PORTS*ADDR_W-1:0]   i_wr_addr;
  logic [WR_PORTS*DATA_W-1:0]   i_wr_data;
  logic [RD_PORTS-1:0]          i_ren;
  logic [RD_PORTS*ADDR_W-1:0]   i_rd_addr;
  logic [RD_PORTS*DATA_W-1:0]   o_rd_data;
  logic [RD_PORTS-1:0]          o_rd_valid;
  logic                         o_busy;

  modport master (
    output i_clr, i_wen, i_wr_addr, i_wr_data, i_ren, i_rd_addr,
    input  o_rd_data, o_rd_valid, o_busy
  );

  modport slave (
    input  i_clr, i_wen, i_wr_addr, i_wr_data, i_ren, i_rd_addr,
    output o_rd_data, o_rd_valid, o_busy
  );

endinterface

// File: rtl/zap_regf_mp_fwd_sel.sv
`timescale 1ns/1ps
// Per-read-port word select: optional same-cycle write forwarding (highest write port wins)
// and zero for addresses beyond the array.
module zap_regf_mp_fwd_sel #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned WR_PORTS = 2,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic [ADDR_W-1:0]          rd_addr_i,
  input  logic [WR_PORTS-1:0]        wen_i,
  input  logic [WR_PORTS*ADDR_W-1:0] wr_addr_i,
  input  logic [WR_PORTS*DATA_W-1:0] wr_data_i,
  input  logic [DATA_W-1:0]          mem_word_i,
  output logic [DATA_W-1:0]          word_o
);

  localparam int unsigned        AddrExtW = ADDR_W + 1;
  localparam logic [ADDR_W:0]    DepthExt = AddrExtW'(DEPTH);

  always_comb begin
    word_o = mem_word_i;
    if (BYPASS) begin
      // Later ports overwrite earlier matches, mirroring the array's write priority.
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (wen_i[p] && (wr_addr_i[p*ADDR_W +: ADDR_W] == rd_addr_i)) begin
          word_o = wr_data_i[p*DATA_W +: DATA_W];
        end
      end
    end
    if ({1'b0, rd_addr_i} >= DepthExt) begin
      word_o = '0;
    end
  end

endmodule

// File: rtl/zap_regf_mp.sv
`timescale 1ns/1ps
// Parametrised multi-port register file with write priority, optional bypass and a
// self-sequencing clear engine that zeroes the array after reset or on request.
module zap_regf_mp
  import zap_regf_mp_pkg::*;
#(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned DEPTH    = 64,
  parameter int unsigned ADDR_W   = $clog2(DEPTH),
  parameter int unsigned RD_PORTS = 4,
  parameter int unsigned WR_PORTS = 2,
  parameter bit          BYPASS   = 1'b1
) (
  input logic          i_clk,
  input logic          i_reset_n,
  zap_regf_mp_if.slave bus
);

  localparam int unsigned     AddrExtW = ADDR_W + 1;
  localparam logic [ADDR_W:0] DepthExt = AddrExtW'(DEPTH);
  localparam logic [ADDR_W-1:0] PtrLast = ADDR_W'(DEPTH - 1);

  regf_state_e                state_q;
  logic [ADDR_W-1:0]          ptr_q;
  logic                       busy_q;
  logic [DATA_W-1:0]          mem_q [DEPTH];
  logic [RD_PORTS*DATA_W-1:0] rd_data_q;
  logic [RD_PORTS-1:0]        rd_valid_q;
  logic [RD_PORTS*DATA_W-1:0] arr_word;
  logic [RD_PORTS*DATA_W-1:0] sel_word;
  logic [WR_PORTS-1:0]        wr_in_range;
  logic                       idle;

  assign idle = (state_q == StIdle);

  // Clear engine: one entry per edge, then idle until the next clear request.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= StClear;
      ptr_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      unique case (state_q)
        StClear: begin
          if (ptr_q == PtrLast) begin
            state_q <= StIdle;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            ptr_q <= ptr_q + ADDR_W'(1);
          end
        end
        StIdle: begin
          if (bus.i_clr) begin
            state_q <= StClear;
            ptr_q   <= '0;
            busy_q  <= 1'b1;
          end
        end
      endcase
    end
  end

  always_comb begin
    wr_in_range = '0;
    for (int unsigned p = 0; p < WR_PORTS; p++) begin
      wr_in_range[p] = ({1'b0, bus.i_wr_addr[p*ADDR_W +: ADDR_W]} < DepthExt);
    end
  end

  // Storage is deliberately not reset; the clear engine owns initialisation.
  always_ff @(posedge i_clk) begin
    if (!idle) begin
      mem_q[ptr_q] <= '0;
    end else begin
      for (int unsigned p = 0; p < WR_PORTS; p++) begin
        if (bus.i_wen[p] && wr_in_range[p]) begin
          mem_q[bus.i_wr_addr[p*ADDR_W +: ADDR_W]] <= bus.i_wr_data[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    arr_word = '0;
    for (int unsigned r = 0; r < RD_PORTS; r++) begin
      if ({1'b0, bus.i_rd_addr[r*ADDR_W +: ADDR_W]} < DepthExt) begin
        arr_word[r*DATA_W +: DATA_W] = mem_q[bus.i_rd_addr[r*ADDR_W +: ADDR_W]];
      end
    end
  end

  for (genvar r = 0; r < RD_PORTS; r++) begin : g_rd
    zap_regf_mp_fwd_sel #(
      .DATA_W   (DATA_W),
      .DEPTH    (DEPTH),
      .ADDR_W   (ADDR_W),
      .WR_PORTS (WR_PORTS),
      .BYPASS   (BYPASS)
    ) u_fwd_sel (
      .rd_addr_i  (bus.i_rd_addr[r*ADDR_W +: ADDR_W]),
      .wen_i      (bus.i_wen),
      .wr_addr_i  (bus.i_wr_addr),
      .wr_data_i  (bus.i_wr_data),
      .mem_word_i (arr_word[r*DATA_W +: DATA_W]),
      .word_o     (sel_word[r*DATA_W +: DATA_W])
    );
  end

  // Disabled ports and reads during a clear keep their last data and report not-valid.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= '0;
    end else begin
      for (int unsigned r = 0; r < RD_PORTS; r++) begin
        rd_valid_q[r] <= idle && bus.i_ren[r];
        if (idle && bus.i_ren[r]) begin
          rd_data_q[r*DATA_W +: DATA_W] <= sel_word[r*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign bus.o_rd_data  = rd_data_q;
  assign bus.o_rd_valid = rd_valid_q;
  assign bus.o_busy     = busy_q;

endmodule

// File: tb/tb_zap_regf_mp.sv
`timescale 1ns/1ps
// Bench for zap_regf_mp: a 64-deep bypassing instance and a 40-deep non-bypassing one,
// checked against an array model of the register file.
module tb_zap_regf_mp;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 6;
  localparam int unsigned RP = 4;
  localparam int unsigned WP = 2;

  logic clk = 1'b0;
  logic rst_a_n;
  logic rst_b_n;

  always #5 clk = ~clk;

  zap_regf_mp_if #(.DATA_W(DW), .DEPTH(64)) bus_a ();
  zap_regf_mp_if #(.DATA_W(DW), .DEPTH(40)) bus_b ();

  zap_regf_mp #(.DATA_W(DW), .DEPTH(64), .BYPASS(1'b1)) u_dut_a (
    .i_clk     (clk),
    .i_reset_n (rst_a_n),
    .bus       (bus_a)
  );

  zap_regf_mp #(.DATA_W(DW), .DEPTH(40), .BYPASS(1'b0)) u_dut_b (
    .i_clk     (clk),
    .i_reset_n (rst_b_n),
    .bus       (bus_b)
  );

  typedef struct {
    logic [WP-1:0]    wen;
    logic [WP*AW-1:0] waddr;
    logic [WP*DW-1:0] wdata;
    logic [RP-1:0]    ren;
    logic [RP*AW-1:0] raddr;
    logic [RP-1:0]    exp_valid;
    logic [RP*DW-1:0] exp_data;
  } vec_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [DW-1:0] mem_m  [2][64];
  logic [DW-1:0] hold_m [2][RP];
  int unsigned   depth_m [2];
  bit            bypass_m [2];
  vec_t          vecs [7];

  function automatic void check(input string name, input logic [127:0] act,
                                input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [RP*DW-1:0] rd_data(input int s);
    return (s == 0) ? bus_a.o_rd_data : bus_b.o_rd_data;
  endfunction

  function automatic logic [RP-1:0] rd_valid(input int s);
    return (s == 0) ? bus_a.o_rd_valid : bus_b.o_rd_valid;
  endfunction

  function automatic logic busy(input int s);
    return (s == 0) ? bus_a.o_busy : bus_b.o_busy;
  endfunction

  task automatic drive(input int s, input logic clr, input logic [WP-1:0] wen,
                       input logic [WP*AW-1:0] waddr, input logic [WP*DW-1:0] wdata,
                       input logic [RP-1:0] ren, input logic [RP*AW-1:0] raddr);
    if (s == 0) begin
      bus_a.i_clr = clr; bus_a.i_wen = wen; bus_a.i_wr_addr = waddr;
      bus_a.i_wr_data = wdata; bus_a.i_ren = ren; bus_a.i_rd_addr = raddr;
    end else begin
      bus_b.i_clr = clr; bus_b.i_wen = wen; bus_b.i_wr_addr = waddr;
      bus_b.i_wr_data = wdata; bus_b.i_ren = ren; bus_b.i_rd_addr = raddr;
    end
  endtask

  task automatic zero_model(input int s);
    for (int i = 0; i < 64; i++) mem_m[s][i] = '0;
  endtask

  // One idle-state cycle: apply inputs, predict from the model, compare, then commit writes.
  task automatic cyc(input int s, input logic clr, input logic [WP-1:0] wen,
                     input logic [WP*AW-1:0] waddr, input logic [WP*DW-1:0] wdata,
                     input logic [RP-1:0] ren, input logic [RP*AW-1:0] raddr);
    logic [AW-1:0]    a;
    logic [RP*DW-1:0] got;
    drive(s, clr, wen, waddr, wdata, ren, raddr);
    @(posedge clk);
    #1;
    for (int r = 0; r < RP; r++) begin
      if (ren[r]) begin
        a = raddr[r*AW +: AW];
        if (a >= depth_m[s]) begin
          hold_m[s][r] = '0;
        end else begin
          hold_m[s][r] = mem_m[s][a];
          if (bypass_m[s]) begin
            for (int p = 0; p < WP; p++) begin
              if (wen[p] && waddr[p*AW +: AW] == a) hold_m[s][r] = wdata[p*DW +: DW];
            end
          end
        end
      end
    end
    for (int p = 0; p < WP; p++) begin
      if (wen[p] && waddr[p*AW +: AW] < depth_m[s]) mem_m[s][waddr[p*AW +: AW]] = wdata[p*DW +: DW];
    end
    got = rd_data(s);
    check($sformatf("dut%0d rd_valid", s), rd_valid(s), ren);
    for (int r = 0; r < RP; r++) begin
      check($sformatf("dut%0d rd_data[%0d]", s, r), got[r*DW +: DW], hold_m[s][r]);
    end
    check($sformatf("dut%0d busy", s), busy(s), clr);
  endtask

  // Runs clear edges with refused traffic applied; stops when busy drops or at stop_at.
  task automatic run_clear(input int s, input int stop_at, output int n);
    logic [RP*DW-1:0] got;
    n = 0;
    for (int k = 0; k < 200; k++) begin
      drive(s, (k < 5), 2'b11, {6'd1, 6'd0}, {$urandom, $urandom} | 64'h1, 4'hF,
            {6'd3, 6'd2, 6'd1, 6'd0});
      @(posedge clk);
      #1;
      n++;
      got = rd_data(s);
      check($sformatf("dut%0d clr rd_valid", s), rd_valid(s), 4'h0);
      for (int r = 0; r < RP; r++) begin
        check($sformatf("dut%0d clr hold[%0d]", s, r), got[r*DW +: DW], hold_m[s][r]);
      end
      if (!busy(s) || n == stop_at) break;
    end
    drive(s, 1'b0, '0, '0, '0, '0, '0);
  endtask

  task automatic read_all(input int s);
    logic [RP*AW-1:0] ra;
    for (int b = 0; b < int'(depth_m[s]) / RP; b++) begin
      for (int r = 0; r < RP; r++) ra[r*AW +: AW] = AW'(b * RP + r);
      cyc(s, 1'b0, '0, '0, '0, 4'hF, ra);
    end
  endtask

  task automatic rand_phase(input int s, input int n);
    logic [WP*AW-1:0] wa;
    logic [RP*AW-1:0] ra;
    logic             narrow;
    for (int i = 0; i < n; i++) begin
      narrow = 1'($urandom_range(0, 1));
      for (int p = 0; p < WP; p++)
        wa[p*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
      for (int r = 0; r < RP; r++)
        ra[r*AW +: AW] = narrow ? AW'($urandom_range(0, 7)) : AW'($urandom_range(0, 63));
      cyc(s, 1'b0, 2'($urandom), wa, {$urandom, $urandom}, 4'($urandom), ra);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int na;
    int nb;
    int n;
    logic [RP*DW-1:0] got;

    depth_m[0] = 64; depth_m[1] = 40;
    bypass_m[0] = 1'b1; bypass_m[1] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      zero_model(s);
      for (int r = 0; r < RP; r++) hold_m[s][r] = '0;
    end

    vecs[0] = '{2'b11, {6'd5, 6'd5}, {32'h12345678, 32'hDEADBEEF}, 4'b0000, 24'd0,
                4'b0000, 128'd0};
    vecs[1] = '{2'b00, 12'd0, 64'd0, 4'b0001, {6'd0, 6'd0, 6'd0, 6'd5},
                4'b0001, {96'd0, 32'h12345678}};
    vecs[2] = '{2'b01, {6'd0, 6'd9}, {32'd0, 32'hA5A5A5A5}, 4'b0100, {6'd0, 6'd9, 6'd0, 6'd0},
                4'b0100, {32'd0, 32'hA5A5A5A5, 64'd0}};
    vecs[3] = '{2'b00, 12'd0, 64'd0, 4'b1111, {6'd63, 6'd0, 6'd5, 6'd9},
                4'b1111, {32'd0, 32'd0, 32'h12345678, 32'hA5A5A5A5}};
    vecs[4] = '{2'b11, {6'd0, 6'd0}, {32'h22222222, 32'h11111111}, 4'b1010, 24'd0,
                4'b1010, {32'h22222222, 32'd0, 32'h22222222, 32'd0}};
    vecs[5] = '{2'b00, 12'd0, 64'd0, 4'b0001, 24'd0, 4'b0001, {96'd0, 32'h22222222}};
    vecs[6] = '{2'b10, {6'd63, 6'd0}, {32'h0F0F0F0F, 32'd0}, 4'b0011,
                {6'd0, 6'd0, 6'd62, 6'd63}, 4'b0011, {96'd0, 32'h0F0F0F0F}};

    rst_a_n = 1'b0;
    rst_b_n = 1'b0;
    drive(0, 1'b0, '0, '0, '0, '0, '0);
    drive(1, 1'b0, '0, '0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      check($sformatf("dut%0d reset rd_data", s), rd_data(s), '0);
      check($sformatf("dut%0d reset rd_valid", s), rd_valid(s), '0);
      check($sformatf("dut%0d reset busy", s), busy(s), 1'b1);
    end

    // Busy must drop exactly on the DEPTH-th edge after release.
    @(negedge clk);
    rst_a_n = 1'b1;
    rst_b_n = 1'b1;
    na = 0;
    nb = 0;
    for (int k = 1; k <= 150; k++) begin
      @(posedge clk);
      #1;
      if (na == 0 && !busy(0)) na = k;
      if (nb == 0 && !busy(1)) nb = k;
      if (na != 0 && nb != 0) break;
    end
    check("dut0 initial clear edges", na, 64);
    check("dut1 initial clear edges", nb, 40);

    read_all(0);

    for (int i = 0; i < 7; i++) begin
      cyc(0, 1'b0, vecs[i].wen, vecs[i].waddr, vecs[i].wdata, vecs[i].ren, vecs[i].raddr);
      got = rd_data(0);
      check($sformatf("vec%0d valid", i), rd_valid(0), vecs[i].exp_valid);
      for (int r = 0; r < RP; r++) begin
        if (vecs[i].exp_valid[r])
          check($sformatf("vec%0d data[%0d]", i, r), got[r*DW +: DW],
                vecs[i].exp_data[r*DW +: DW]);
      end
    end

    // Clear request: the read in the request cycle still completes.
    cyc(0, 1'b1, '0, '0, '0, 4'b0001, {18'd0, 6'd5});
    check("dut0 clr-cycle read", hold_m[0][0], 32'h12345678);
    run_clear(0, 0, n);
    check("dut0 requested clear edges", n, 64);
    zero_model(0);
    read_all(0);
    rand_phase(0, 300);

    // Non-bypassing instance returns the pre-write value.
    cyc(1, 1'b0, 2'b01, {6'd0, 6'd9}, {32'd0, 32'hA5A5A5A5}, 4'b0100, {6'd0, 6'd9, 12'd0});
    got = rd_data(1);
    check("dut1 no-bypass old value", got[2*DW +: DW], 32'd0);
    cyc(1, 1'b0, '0, '0, '0, 4'b0100, {6'd0, 6'd9, 12'd0});
    got = rd_data(1);
    check("dut1 read after write", got[2*DW +: DW], 32'hA5A5A5A5);

    cyc(1, 1'b0, 2'b01, {6'd0, 6'd45}, {32'd0, 32'hFFFFFFFF}, '0, '0);
    cyc(1, 1'b0, '0, '0, '0, 4'b0011, {12'd0, 6'd39, 6'd45});
    got = rd_data(1);
    check("dut1 oob read 45", got[0 +: DW], 32'd0);
    check("dut1 read 39", got[DW +: DW], 32'd0);
    check("dut1 oob valid", rd_valid(1), 4'b0011);

    rand_phase(1, 300);

    // Reset in the middle of a clear restarts the whole sequence.
    cyc(1, 1'b0, 2'b01, {6'd0, 6'd3}, {32'd0, 32'hCAFEF00D}, '0, '0);
    cyc(1, 1'b0, '0, '0, '0, 4'hF, {6'd3, 6'd3, 6'd3, 6'd3});
    cyc(1, 1'b1, '0, '0, '0, '0, '0);
    run_clear(1, 30, n);
    check("dut1 edges before reset", n, 30);
    rst_b_n = 1'b0;
    #1;
    check("dut1 mid-clear reset rd_data", rd_data(1), '0);
    check("dut1 mid-clear reset rd_valid", rd_valid(1), '0);
    check("dut1 mid-clear reset busy", busy(1), 1'b1);
    for (int r = 0; r < RP; r++) hold_m[1][r] = '0;
    @(negedge clk);
    rst_b_n = 1'b1;
    run_clear(1, 0, n);
    check("dut1 clear edges after reset", n, 40);
    zero_model(1);
    read_all(1);
    rand_phase(1, 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
